prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes 16-bit words into the instruction/data RAM through its write port, then releases the CPU from reset with the entry address on `start_pc`. It sits between an external byte source (UART receiver or test bench) and the CPU/RAM. It holds `cpu_rst_n` low while loading, so the CPU fetches only a fully written program.

## Interface
Parameters:
- none (address width fixed at 8, word width fixed at 16, matching the RAM)

Ports:
- `clk`  input  1  system clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_data`  input  8  stream byte
- `in_valid`  input  1  `in_data` valid
- `in_ready`  output  1  loader can accept a byte; transfer occurs when `in_valid && in_ready` at a rising edge
- `reload`  input  1  restart loading; honoured only in DONE or ERR
- `ram_w_en`  output  1  RAM write strobe, one cycle per word
- `ram_addr`  output  8  RAM write address
- `ram_w_data`  output  16  RAM write data
- `start_pc`  output  8  entry address for the CPU (= base address of the loaded image)
- `cpu_rst_n`  output  1  active-low CPU reset; low until a load completes successfully
- `done`  output  1  load completed
- `err`  output  1  load failed (checksum build only)

## Operation
- Stream format: byte 0 = base address B; byte 1 = word count N (0 means 256); then N words, each high byte first then low byte; then, with checksum enabled, one checksum byte.
- States:
  - HDR_ADDR: accept B.
  - HDR_CNT: accept N.
  - DATA_HI: accept the high byte.
  - DATA_LO: accept the low byte.
  - CKSUM: checksum build only.
  - DONE.
  - ERR.
- State transitions:
  - HDR_ADDR→HDR_CNT on accept; B is latched into the write address and into `start_pc`.
  - HDR_CNT→DATA_HI on accept; the remaining count is loaded (0→256, 9-bit counter).
  - DATA_HI→DATA_LO on accept; the high byte is latched.
  - DATA_LO on accept: registers `ram_w_data` = {hi, lo} and `ram_addr` = current address, and pulses `ram_w_en` for the following cycle. The address then increments mod 256 (0xFF wraps to 0x00) and the count decrements.
  - From DATA_LO, if count was >1 → DATA_HI. Otherwise → FINISH, an internal one-cycle state that exists while the last write is in flight. From FINISH, go to CKSUM if the checksum build is enabled, else DONE.
- `in_ready` = 1 in HDR_ADDR, HDR_CNT, DATA_HI, DATA_LO and CKSUM; 0 in FINISH, DONE and ERR. Bytes offered while `in_ready`=0 are not consumed.
- DONE: `done`=1 and `cpu_rst_n`=1; `start_pc` holds B.
- ERR: `err`=1 and `cpu_rst_n`=0.
- `reload`=1 in DONE or ERR → HDR_ADDR. On that edge `done`, `err` and `cpu_rst_n` drop to 0. `reload` in any other state is ignored.
- Wrap-around: an image crossing 0xFF continues at 0x00. With N=0, all 256 locations are written.

## Timing
- Reset values (asynchronous): state HDR_ADDR, `ram_w_en`=0, `ram_addr`=0, `ram_w_data`=0, `start_pc`=0, `cpu_rst_n`=0, `done`=0, `err`=0. `in_ready`=1 (decoded from HDR_ADDR), but no transfer occurs while `rst_n`=0.
- Word write latency: low byte accepted at edge k → `ram_w_en` high for exactly the cycle between edges k and k+1; the RAM captures the word at edge k+1.
- Back-to-back accepts are sustained at one byte per cycle, giving a peak of one word per two cycles.
- Last low byte accepted at edge k → FINISH during cycle k..k+1. Without checksum, DONE is entered at edge k+1, so `cpu_rst_n` and `done` rise at edge k+1, no earlier than the last RAM write.
- `rst_n` asserted mid-load aborts immediately to reset values. The partial image in RAM is left as written; `ram_w_en` drops at once.

## Configuration
- `PROG_LOADER_CKSUM_EN` defined:
  - CKSUM state present.
  - The running XOR covers every payload byte (header bytes excluded).
  - Checksum byte accepted at edge c: equal to the XOR → DONE at edge c+1; mismatch → ERR at edge c+1.
- `PROG_LOADER_CKSUM_EN` undefined:
  - No CKSUM state and no XOR register.
  - `err` is tied to 0.
  - FINISH goes directly to DONE.

## Test plan
- Basic load: stream 0x10, 0x02, 0x12, 0x34, 0xAB, 0xCD (plus checksum 0x40 if enabled) → writes 0x1234@0x10 and 0xABCD@0x11, one `ram_w_en` pulse each. Then `start_pc`=0x10, `done`=1, `cpu_rst_n`=1 the edge after FINISH.
- Wrap: B=0xFF, N=2, words 0x0001 and 0x0002 → writes land at 0xFF then 0x00.
- Full memory: N=0 → exactly 256 write pulses covering every address once, then DONE.
- Backpressure and gaps: random `in_valid` gaps → identical RAM contents. No byte is consumed in FINISH or DONE, and `in_ready`=0 there.
- Checksum error (with `PROG_LOADER_CKSUM_EN`): basic stream with checksum 0x41 → `err`=1, `cpu_rst_n`=0. Then `reload`=1 followed by a correct stream → DONE.
- Mid-load reset: assert `rst_n`=0 after 3 payload bytes → all outputs at reset values. A new full stream after release loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the 256 x 16-bit instruction/data RAM.
//
// Stream format: base address B, word count N (0 means 256), then N words with
// the high byte first. A checksum byte follows when the checksum build is enabled.
// The CPU is held in reset (cpu_rst_n = 0) until an image has been completely
// written, and start_pc then carries B as the entry address.
//
// Build option: define PROG_LOADER_CKSUM_EN to enable the trailing XOR checksum
// byte and the CKSUM/ERR path. When it is undefined, err is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_data     in   [7:0] stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader accepts a byte (transfer = in_valid && in_ready)
//   reload      in   restart loading, honoured only in DONE or ERR
//   ram_w_en    out  RAM write strobe, one cycle per word
//   ram_addr    out  [7:0] RAM write address
//   ram_w_data  out  [15:0] RAM write data
//   start_pc    out  [7:0] CPU entry address (= B)
//   cpu_rst_n   out  active-low CPU reset, high only after a good load
//   done        out  load completed
//   err         out  checksum mismatch (checksum build only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HDR_ADDR | waiting for base address byte B
// HDR_CNT  | waiting for word count byte N
// DATA_HI  | waiting for high byte of the next word
// DATA_LO  | waiting for low byte; accept launches the RAM write
// FINISH   | last write in flight, no bytes accepted
// CKSUM    | waiting for checksum byte (checksum build only)
// DONE     | image loaded, CPU released
// ERR      | checksum mismatch, CPU held in reset

module prog_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        ram_w_en,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_w_data,
  output logic [7:0]  start_pc,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR_ADDR = 3'd0,
    S_HDR_CNT  = 3'd1,
    S_DATA_HI  = 3'd2,
    S_DATA_LO  = 3'd3,
    S_FINISH   = 3'd4,
`ifdef PROG_LOADER_CKSUM_EN
    S_CKSUM    = 3'd5,
`endif
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;          // next word address
  logic [8:0]  cnt_q, cnt_d;            // words remaining, 256 needs 9 bits
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  start_pc_q, start_pc_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [15:0] ram_w_data_q, ram_w_data_d;
  logic        ram_w_en_q, ram_w_en_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic accept;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR_ADDR, S_HDR_CNT, S_DATA_HI, S_DATA_LO: in_ready = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM:                                     in_ready = 1'b1;
`endif
      default:                                     in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    start_pc_d   = start_pc_q;
    ram_addr_d   = ram_addr_q;
    ram_w_data_d = ram_w_data_q;
    ram_w_en_d   = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    xor_d        = xor_q;
`endif

    case (state_q)
      S_HDR_ADDR: begin
        if (accept) begin
          addr_d     = in_data;
          start_pc_d = in_data;
          state_d    = S_HDR_CNT;
        end
      end
      S_HDR_CNT: begin
        if (accept) begin
          cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
`ifdef PROG_LOADER_CKSUM_EN
          xor_d   = 8'd0;
`endif
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
`ifdef PROG_LOADER_CKSUM_EN
          xor_d   = xor_q ^ in_data;
`endif
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          ram_w_data_d = {hi_q, in_data};
          ram_addr_d   = addr_q;
          ram_w_en_d   = 1'b1;
          addr_d       = addr_q + 8'd1;   // wraps 0xFF -> 0x00
          cnt_d        = cnt_q - 9'd1;
`ifdef PROG_LOADER_CKSUM_EN
          xor_d        = xor_q ^ in_data;
`endif
          state_d      = (cnt_q > 9'd1) ? S_DATA_HI : S_FINISH;
        end
      end
      S_FINISH: begin
`ifdef PROG_LOADER_CKSUM_EN
        state_d = S_CKSUM;
`else
        state_d = S_DONE;
`endif
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (reload) state_d = S_HDR_ADDR;
      end
      default: state_d = S_HDR_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR_ADDR;
      addr_q       <= 8'd0;
      cnt_q        <= 9'd0;
      hi_q         <= 8'd0;
      start_pc_q   <= 8'd0;
      ram_addr_q   <= 8'd0;
      ram_w_data_q <= 16'd0;
      ram_w_en_q   <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      start_pc_q   <= start_pc_d;
      ram_addr_q   <= ram_addr_d;
      ram_w_data_q <= ram_w_data_d;
      ram_w_en_q   <= ram_w_en_d;
`ifdef PROG_LOADER_CKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign ram_w_en   = ram_w_en_q;
  assign ram_addr   = ram_addr_q;
  assign ram_w_data = ram_w_data_q;
  assign start_pc   = start_pc_q;
  // Status decoded from the registered state, so it changes exactly on the
  // entry/reload edge and is forced low by reset.
  assign done       = (state_q == S_DONE);
  assign cpu_rst_n  = (state_q == S_DONE);
`ifdef PROG_LOADER_CKSUM_EN
  assign err        = (state_q == S_ERR);
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        ram_w_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_w_data;
  logic [7:0]  start_pc;
  logic        cpu_rst_n;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .ram_w_en(ram_w_en),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .start_pc(start_pc),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] words[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  int          hits[256];
  logic [15:0] ram_model[256];
  wr_t         mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && ram_w_en) begin
      n_writes++;
      hits[ram_addr]++;
      ram_model[ram_addr] = ram_w_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", ram_addr, ram_w_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {24'd0, ram_addr}, {24'd0, mon_e.a});
        check("wr_data", {16'd0, ram_w_data}, {16'd0, mon_e.d});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},  32'd1);
    check({tag, "_ram_w_en"},   {31'd0, ram_w_en},  32'd0);
    check({tag, "_ram_addr"},   {24'd0, ram_addr},  32'd0);
    check({tag, "_ram_w_data"}, {16'd0, ram_w_data}, 32'd0);
    check({tag, "_start_pc"},   {24'd0, start_pc},  32'd0);
    check({tag, "_cpu_rst_n"},  {31'd0, cpu_rst_n}, 32'd0);
    check({tag, "_done"},       {31'd0, done},      32'd0);
    check({tag, "_err"},        {31'd0, err},       32'd0);
  endtask

  // Offer one byte after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      reload = 1'($urandom_range(0, 1));   // must be ignored mid-load
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    reload   = 1'($urandom_range(0, 1));
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for byte 0x%0h", b);
    end
    @(posedge clk);
  endtask

  task automatic do_reload();
    @(negedge clk);
    in_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_done",      {31'd0, done},      32'd0);
    check("reload_err",       {31'd0, err},       32'd0);
    check("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("reload_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  task automatic fill_random(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back(16'($urandom));
  endtask

  // Full load of 'words' at base b with count byte n; bad selects a wrong checksum.
  task automatic load(input logic [7:0] b, input logic [7:0] n, input int gapmax, input bit bad);
    int          cnt;
    logic [7:0]  ck;
    logic [15:0] w;
    cnt = (n == 8'd0) ? 256 : int'(n);
    ck = 8'd0;
    if (done || err) do_reload();
    n_writes = 0;
    for (int i = 0; i < 256; i++) hits[i] = 0;
    send_byte(b, $urandom_range(0, gapmax));
    send_byte(n, $urandom_range(0, gapmax));
    for (int i = 0; i < cnt; i++) begin
      w = words[i];
      exp_q.push_back('{a: 8'(int'(b) + i), d: w});
      ck = ck ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], $urandom_range(0, gapmax));
      send_byte(w[7:0],  $urandom_range(0, gapmax));
    end
    // FINISH cycle: last write strobing, nothing accepted; offer a junk byte.
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    check("finish_in_ready", {31'd0, in_ready}, 32'd0);
    check("finish_done",     {31'd0, done},     32'd0);
    check("finish_cpu_rst",  {31'd0, cpu_rst_n}, 32'd0);
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(bad ? (ck ^ 8'h01) : ck, 0);
    @(negedge clk);
    reload   = 1'b0;
    in_data  = 8'hEE;
    check("end_done",      {31'd0, done},      {31'd0, !bad});
    check("end_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, !bad});
    check("end_err",       {31'd0, err},       {31'd0, bad});
`else
    @(negedge clk);
    check("end_done",      {31'd0, done},      32'd1);
    check("end_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("end_err",       {31'd0, err},       32'd0);
`endif
    check("end_start_pc", {24'd0, start_pc}, {24'd0, b});
    check("end_ram_w_en", {31'd0, ram_w_en}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("write_count", n_writes, cnt);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  // Abort a load with rst_n after npay payload bytes (2 = during the write pulse).
  task automatic partial(input int npay);
    fill_random(2);
    if (done || err) do_reload();
    send_byte(8'h40, 0);
    send_byte(8'h02, 1);
    if (npay == 3) exp_q.push_back('{a: 8'h40, d: words[0]});
    send_byte(words[0][15:8], 0);
    send_byte(words[0][7:0], 0);
    if (npay == 3) send_byte(words[1][15:8], 1);
    #1;
    if (npay == 2) check("pre_rst_w_en", {31'd0, ram_w_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    reload = 1'b0;
    rst_n = 1'b1;
    check("midrst_exp_q", exp_q.size(), 0);
  endtask

  int bad_hits;

  initial begin
    // Reset with a byte offered: nothing may be consumed.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Basic load.
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    load(8'h10, 8'h02, 0, 1'b0);
    check("basic_ram_10", {16'd0, ram_model[8'h10]}, 32'h1234);
    check("basic_ram_11", {16'd0, ram_model[8'h11]}, 32'hABCD);

    // Wrap across 0xFF.
    words.delete();
    words.push_back(16'h0001);
    words.push_back(16'h0002);
    load(8'hFF, 8'h02, 2, 1'b0);
    check("wrap_ram_ff", {16'd0, ram_model[8'hFF]}, 32'h0001);
    check("wrap_ram_00", {16'd0, ram_model[8'h00]}, 32'h0002);

    // Full memory.
    fill_random(256);
    load(8'($urandom), 8'h00, 0, 1'b0);
    bad_hits = 0;
    for (int i = 0; i < 256; i++) if (hits[i] != 1) bad_hits++;
    check("full_each_addr_once", bad_hits, 0);

    // Random loads with gaps.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(n);
      load(8'($urandom), 8'(n), 3, 1'b0);
    end

`ifdef PROG_LOADER_CKSUM_EN
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    load(8'h10, 8'h02, 0, 1'b1);
    load(8'h10, 8'h02, 1, 1'b0);
`endif

    // Mid-load resets, each followed by a clean load.
    partial(3);
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    load(8'h10, 8'h02, 1, 1'b0);
    partial(2);
    fill_random(7);
    load(8'hFC, 8'h07, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
